// File: rtl/dda_ctrl_pkg.sv
// Shared constants for the DDA host-command controller: opcodes, reply codes,
// receive FSM states and error-flag bit positions.
package dda_ctrl_pkg;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_G = 8'h47;
  localparam logic [7:0] OP_H = 8'h48;
  localparam logic [7:0] OP_S = 8'h53;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_PAY  = 2'd1,
    ST_RX_CSUM = 2'd2,
    ST_TX      = 2'd3
  } state_e;

  localparam int ERR_CSUM = 0;
  localparam int ERR_TMO  = 1;
  localparam int ERR_OP   = 2;

endpackage

// File: rtl/dda_ctrl_txseq.sv
// Reply sequencer: holds up to OUT_BYTES bytes plus an optional trailing XOR byte and
// paces them out with a tx_start pulse, two guard cycles, then a wait for tx_busy low.
module dda_ctrl_txseq
  import dda_ctrl_pkg::*;
#(
  parameter int OUT_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   load_rd_i,
  input  logic [7:0]             load_byte_i,
  input  logic [8*OUT_BYTES-1:0] state_i,
  input  logic                   tx_busy_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_byte_o,
  output logic                   done_o
);

  localparam int IW = $clog2(OUT_BYTES + 2);

  logic [8*OUT_BYTES-1:0] q_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          cnt_q;
  logic [7:0]             xor_q;
  logic [1:0]             guard_q;
  logic                   active_q;
  logic                   rd_q;
  logic                   tx_start_q;
  logic [7:0]             tx_byte_q;
  logic [7:0]             next_byte;
  logic                   line_free;

  // A readback reply ends with the XOR of the data bytes already sent.
  always_comb begin
    next_byte = q_q[8*OUT_BYTES-1 -: 8];
    if (rd_q && idx_q == IW'(OUT_BYTES)) next_byte = xor_q;
  end

  assign line_free = active_q && !tx_start_q && guard_q == 2'd0 && !tx_busy_i;
  assign done_o    = line_free && idx_q == cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      guard_q    <= '0;
      active_q   <= 1'b0;
      rd_q       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else if (load_i) begin
      q_q        <= load_rd_i ? state_i
                              : (8*OUT_BYTES)'(load_byte_i) << (8*(OUT_BYTES-1));
      rd_q       <= load_rd_i;
      cnt_q      <= load_rd_i ? IW'(OUT_BYTES + 1) : IW'(1);
      idx_q      <= '0;
      xor_q      <= '0;
      guard_q    <= '0;
      active_q   <= 1'b1;
      tx_start_q <= 1'b0;
    end else if (active_q) begin
      if (tx_start_q) begin
        tx_start_q <= 1'b0;
        guard_q    <= 2'd2;
      end else if (guard_q != 2'd0) begin
        guard_q <= guard_q - 2'd1;
      end else if (!tx_busy_i) begin
        if (idx_q == cnt_q) begin
          active_q <= 1'b0;
        end else begin
          tx_start_q <= 1'b1;
          tx_byte_q  <= next_byte;
          xor_q      <= xor_q ^ next_byte;
          q_q        <= q_q << 8;
          idx_q      <= idx_q + 1'b1;
        end
      end
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_byte_o  = tx_byte_q;

endmodule

// File: rtl/dda_host_ctrl.sv
// Opcode-framed host controller between the byte UART and the DDA solver: checksummed
// config writes, state readback, run/halt/step, and an inter-byte receive timeout.
module dda_host_ctrl
  import dda_ctrl_pkg::*;
#(
  parameter int CFG_BYTES   = 10,
  parameter int OUT_BYTES   = 4,
  parameter int TIMEOUT_CYC = 52080
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  output logic [8*CFG_BYTES-1:0] cfg,
  output logic                   cfg_update,
  input  logic [8*OUT_BYTES-1:0] state_in,
  output logic                   core_en,
  output logic                   busy,
  output logic [2:0]             err_pulse
);

  localparam int PW = $clog2(CFG_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q;
  logic [8*CFG_BYTES-1:0] shadow_q;
  logic [8*CFG_BYTES-1:0] cfg_q;
  logic [PW-1:0]          pay_cnt_q;
  logic [7:0]             csum_q;
  logic [TW-1:0]          tmo_q;
  logic                   cfg_update_q;
  logic                   core_en_q;
  logic                   step_q;
  logic [2:0]             err_q;

  logic                   tmo_hit;
  logic                   seq_load;
  logic                   seq_rd;
  logic [7:0]             seq_byte;
  logic                   seq_done;

  // Decide, on the edge that ends a frame, which reply gets queued.
  always_comb begin
    seq_load = 1'b0;
    seq_rd   = 1'b0;
    seq_byte = NAK;
    tmo_hit  = (state_q == ST_RX_PAY || state_q == ST_RX_CSUM) && !rx_valid &&
               tmo_q == TW'(TIMEOUT_CYC - 1);
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            OP_W:             seq_load = 1'b0;
            OP_R:             begin seq_load = 1'b1; seq_rd = 1'b1; end
            OP_G, OP_H, OP_S: begin seq_load = 1'b1; seq_byte = ACK; end
            default:          seq_load = 1'b1;
          endcase
        end
      end
      ST_RX_PAY:  seq_load = tmo_hit;
      ST_RX_CSUM: begin
        if (rx_valid) begin
          seq_load = 1'b1;
          seq_byte = (rx_byte == csum_q) ? ACK : NAK;
        end else begin
          seq_load = tmo_hit;
        end
      end
      default: seq_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      cfg_q        <= '0;
      pay_cnt_q    <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      cfg_update_q <= 1'b0;
      core_en_q    <= 1'b0;
      step_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      cfg_update_q <= 1'b0;
      err_q        <= '0;
      if (step_q) begin
        core_en_q <= 1'b0;
        step_q    <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            state_q <= ST_TX;
            case (rx_byte)
              OP_W: begin
                state_q   <= ST_RX_PAY;
                pay_cnt_q <= '0;
                csum_q    <= '0;
                tmo_q     <= '0;
              end
              OP_R: step_q <= 1'b0;
              OP_G: core_en_q <= 1'b1;
              OP_H: core_en_q <= 1'b0;
              OP_S: begin
                if (!core_en_q) begin
                  core_en_q <= 1'b1;
                  step_q    <= 1'b1;
                end
              end
              default: err_q[ERR_OP] <= 1'b1;
            endcase
          end
        end
        ST_RX_PAY: begin
          if (rx_valid) begin
            // Shift in from the bottom so byte 0 ends up in the MSBs.
            shadow_q <= (8*CFG_BYTES)'({shadow_q, rx_byte});
            csum_q   <= csum_q ^ rx_byte;
            tmo_q    <= '0;
            if (pay_cnt_q == PW'(CFG_BYTES - 1)) state_q <= ST_RX_CSUM;
            else                                 pay_cnt_q <= pay_cnt_q + 1'b1;
          end else if (tmo_hit) begin
            err_q[ERR_TMO] <= 1'b1;
            state_q        <= ST_TX;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_RX_CSUM: begin
          if (rx_valid) begin
            state_q <= ST_TX;
            if (rx_byte == csum_q) begin
              cfg_q        <= shadow_q;
              cfg_update_q <= 1'b1;
              core_en_q    <= 1'b0;
            end else begin
              err_q[ERR_CSUM] <= 1'b1;
            end
          end else if (tmo_hit) begin
            err_q[ERR_TMO] <= 1'b1;
            state_q        <= ST_TX;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_TX: begin
          if (seq_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dda_ctrl_txseq #(
    .OUT_BYTES(OUT_BYTES)
  ) u_txseq (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (seq_load),
    .load_rd_i  (seq_rd),
    .load_byte_i(seq_byte),
    .state_i    (state_in),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_byte_o  (tx_byte),
    .done_o     (seq_done)
  );

  assign cfg        = cfg_q;
  assign cfg_update = cfg_update_q;
  assign core_en    = core_en_q;
  assign busy       = (state_q != ST_IDLE);
  assign err_pulse  = err_q;

endmodule

// File: tb/tb_dda_host_ctrl.sv
// Randomised frame-level bench for dda_host_ctrl with a byte-level UART responder.
module tb_dda_host_ctrl;

  localparam int CFGB = 10;
  localparam int OUTB = 4;
  localparam int TMO  = 300;

  localparam int K_WGOOD = 0, K_WBAD = 1, K_R = 2, K_G = 3, K_H = 4, K_S = 5, K_BAD = 6, K_TMO = 7;

  logic              clk;
  logic              rst_n;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic [8*CFGB-1:0] cfg;
  logic              cfg_update;
  logic [8*OUTB-1:0] state_in;
  logic              core_en;
  logic              busy;
  logic [2:0]        err_pulse;

  dda_host_ctrl #(
    .CFG_BYTES  (CFGB),
    .OUT_BYTES  (OUTB),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .cfg       (cfg),
    .cfg_update(cfg_update),
    .state_in  (state_in),
    .core_en   (core_en),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state of the solver-facing outputs, tracked at frame granularity.
  logic [8*CFGB-1:0] exp_cfg;
  logic              exp_core;

  logic [7:0] reply_q[$];
  int         cyc = 0;
  int         last_rx_cyc = 0;
  int         err1_cyc = 0;
  int         n_upd = 0;
  int         n_core_hi = 0;
  int         n_err[3];

  // UART transmitter responder: captures bytes and holds tx_busy for a random time.
  initial begin
    int   busy_cnt;
    logic seen_busy;
    logic prev_start;
    tx_busy    = 1'b0;
    busy_cnt   = 0;
    prev_start = 1'b0;
    forever begin
      @(posedge clk);
      seen_busy = tx_busy;
      #1;
      if (!rst_n) begin
        tx_busy    = 1'b0;
        busy_cnt   = 0;
        prev_start = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (tx_start) begin
          chk("tx_start_while_busy", seen_busy, 1'b0);
          chk("tx_start_width", prev_start, 1'b0);
          reply_q.push_back(tx_byte);
          busy_cnt = $urandom_range(0, 8);
          tx_busy  = (busy_cnt > 0);
        end
        prev_start = tx_start;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rx_valid) last_rx_cyc = cyc;
      if (cfg_update) n_upd++;
      if (core_en) n_core_hi++;
      for (int i = 0; i < 3; i++) if (err_pulse[i]) n_err[i]++;
      if (err_pulse[1]) err1_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_frame(input int kind, input logic [8*CFGB-1:0] pay, input logic [7:0] flip,
                           input logic [7:0] op_in, input logic [31:0] st, input int npart);
    logic [7:0] fr[$];
    logic [7:0] ex[$];
    logic [7:0] x;
    int         e[3];
    int         e_upd;
    int         s_pulse;
    bit         changed;
    int         wait_n;
    e       = '{0, 0, 0};
    e_upd   = 0;
    s_pulse = -1;
    changed = 0;
    fr.delete();
    ex.delete();
    reply_q.delete();
    case (kind)
      K_WGOOD, K_WBAD: begin
        fr.push_back(8'h57);
        x = 8'h00;
        for (int i = CFGB - 1; i >= 0; i--) begin
          fr.push_back(pay[8*i +: 8]);
          x ^= pay[8*i +: 8];
        end
        if (kind == K_WGOOD) begin
          fr.push_back(x);
          ex.push_back(8'h06);
          exp_cfg  = pay;
          exp_core = 1'b0;
          e_upd    = 1;
        end else begin
          fr.push_back(x ^ flip);
          ex.push_back(8'h15);
          e[0] = 1;
        end
      end
      K_R: begin
        state_in = st;
        fr.push_back(8'h52);
        x = 8'h00;
        for (int i = OUTB - 1; i >= 0; i--) begin
          ex.push_back(st[8*i +: 8]);
          x ^= st[8*i +: 8];
        end
        ex.push_back(x);
      end
      K_G: begin fr.push_back(8'h47); ex.push_back(8'h06); exp_core = 1'b1; end
      K_H: begin fr.push_back(8'h48); ex.push_back(8'h06); exp_core = 1'b0; end
      K_S: begin
        fr.push_back(8'h53);
        ex.push_back(8'h06);
        if (!exp_core) s_pulse = 1;
      end
      K_BAD: begin fr.push_back(op_in); ex.push_back(8'h15); e[2] = 1; end
      default: begin
        fr.push_back(8'h57);
        for (int i = 0; i < npart; i++) fr.push_back(pay[8*(CFGB-1-i) +: 8]);
        ex.push_back(8'h15);
        e[1] = 1;
      end
    endcase
    n_upd = 0;
    n_core_hi = 0;
    n_err = '{0, 0, 0};
    for (int i = 0; i < fr.size(); i++)
      send_byte(fr[i], (i == fr.size() - 1) ? 0 : $urandom_range(0, 3));
    wait_n = 0;
    while (busy && wait_n < 3000) begin
      @(negedge clk);
      wait_n++;
      if (kind == K_R && !changed && reply_q.size() == 1) begin
        state_in = ~st;
        changed  = 1;
      end
    end
    chk("reply_done_in_time", busy, 1'b0);
    chk("reply_len", reply_q.size(), ex.size());
    for (int i = 0; i < ex.size() && i < reply_q.size(); i++) chk("reply_byte", reply_q[i], ex[i]);
    chk("cfg", cfg, exp_cfg);
    chk("core_en", core_en, exp_core);
    chk("cfg_update_pulses", n_upd, e_upd);
    chk("err_csum_pulses", n_err[0], e[0]);
    chk("err_tmo_pulses", n_err[1], e[1]);
    chk("err_op_pulses", n_err[2], e[2]);
    if (s_pulse >= 0) chk("step_cycles", n_core_hi, s_pulse);
    if (kind == K_TMO) chk("timeout_delay", err1_cyc - last_rx_cyc, TMO);
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  function automatic logic [8*CFGB-1:0] rnd_pay();
    logic [8*CFGB-1:0] p;
    for (int i = 0; i < CFGB; i++) p[8*i +: 8] = 8'($urandom);
    return p;
  endfunction

  function automatic logic [7:0] rnd_badop();
    logic [7:0] o;
    do o = 8'($urandom); while (o == 8'h57 || o == 8'h52 || o == 8'h47 || o == 8'h48 || o == 8'h53);
    return o;
  endfunction

  initial begin
    logic [8*CFGB-1:0] seq_pay;
    int                wait_n;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    state_in = '0;
    exp_cfg  = '0;
    exp_core = 1'b0;
    for (int i = 0; i < CFGB; i++) seq_pay[8*(CFGB-1-i) +: 8] = 8'(i + 1);
    #1;
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_cfg", cfg, '0);
    chk("rst_cfg_update", cfg_update, 1'b0);
    chk("rst_core_en", core_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_pulse, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(K_WGOOD, seq_pay, 8'h00, 8'h00, 32'h0, 0);
    chk("cfg_value", cfg, 80'h0102030405060708090A);
    run_frame(K_WBAD, seq_pay, 8'h07, 8'h00, 32'h0, 0);
    run_frame(K_R, '0, 8'h00, 8'h00, 32'h12345678, 0);
    run_frame(K_G, '0, 8'h00, 8'h00, 32'h0, 0);
    run_frame(K_H, '0, 8'h00, 8'h00, 32'h0, 0);
    run_frame(K_S, '0, 8'h00, 8'h00, 32'h0, 0);
    run_frame(K_TMO, rnd_pay(), 8'h00, 8'h00, 32'h0, 3);
    run_frame(K_R, '0, 8'h00, 8'h00, $urandom, 0);
    run_frame(K_BAD, '0, 8'h00, 8'hFF, 32'h0, 0);
    run_frame(K_G, '0, 8'h00, 8'h00, 32'h0, 0);
    run_frame(K_S, '0, 8'h00, 8'h00, 32'h0, 0);
    run_frame(K_TMO, rnd_pay(), 8'h00, 8'h00, 32'h0, CFGB);

    for (int n = 0; n < 40; n++)
      run_frame($urandom_range(0, 7), rnd_pay(), 8'($urandom_range(1, 255)), rnd_badop(),
                $urandom, $urandom_range(0, CFGB));

    // Reset while a readback reply is on the wire.
    reply_q.delete();
    state_in = $urandom;
    send_byte(8'h52, 0);
    wait_n = 0;
    while (reply_q.size() == 0 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk("mid_reply_started", reply_q.size() > 0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_tx_start", tx_start, 1'b0);
    chk("arst_tx_byte", tx_byte, 8'h00);
    chk("arst_cfg", cfg, '0);
    chk("arst_cfg_update", cfg_update, 1'b0);
    chk("arst_core_en", core_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", err_pulse, 3'b000);
    exp_cfg  = '0;
    exp_core = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(K_G, '0, 8'h00, 8'h00, 32'h0, 0);
    run_frame(K_WGOOD, rnd_pay(), 8'h00, 8'h00, 32'h0, 0);
    run_frame(K_R, '0, 8'h00, 8'h00, $urandom, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
    $finish;
  end

endmodule
